// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port round-robin arbiter in front of a single-port D-MEM.
// Each granted port runs one 32-bit word transaction:
//   - read
//   - full write (be = F)
//   - no-op write (be = 0)
//   - partial write, done as a read-merge-write
//
// Ports
//   clk, reset            clock, synchronous active-low reset
//   req, we               per-port request / write flag (bit 0 = CPU, bit 1 = debug/DMA)
//   addr0/1, wdata0/1     per-port byte address and write data
//   be0/1                 per-port byte enables
//   gnt, done             per-port grant pulse (grant cycle), completion pulse
//   rdata0/1              per-port read data, held until the next read on that port
//   busy                  high when the FSM is not IDLE
//   mem_addr              D-MEM word index
//   mem_write_data        D-MEM write data
//   mem_read_data         D-MEM asynchronous read data
//   mem_read, mem_write   D-MEM strobes
//
// state  | meaning
// IDLE   | waiting for a request; grants and latches one port
// ACCESS | first memory cycle (read, full write, or read half of a partial write)
// MERGE  | write half of a partial write, using the merged word
module dmem_arbiter #(
   parameter int ADDR_W = 8   // must be >= 8; the word index is taken from addr[7:2]
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [1:0]        req,
   input  logic [1:0]        we,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [31:0]       wdata0,
   input  logic [31:0]       wdata1,
   input  logic [3:0]        be0,
   input  logic [3:0]        be1,
   output logic [1:0]        gnt,
   output logic [1:0]        done,
   output logic [31:0]       rdata0,
   output logic [31:0]       rdata1,
   output logic              busy,
   output logic [7:0]        mem_addr,
   output logic [31:0]       mem_write_data,
   input  logic [31:0]       mem_read_data,
   output logic              mem_read,
   output logic              mem_write
);

   typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, MERGE = 2'd2} state_t;

   state_t      state_q, state_d;
   logic        last_q, last_d;
   logic        port_q, port_d;
   logic        we_q, we_d;
   logic [3:0]  be_q, be_d;
   logic [31:0] wdata_q, wdata_d;
   logic [7:0]  maddr_q, maddr_d;
   logic [31:0] merge_q, merge_d;
   logic [31:0] rdata0_q, rdata0_d;
   logic [31:0] rdata1_q, rdata1_d;
   logic [1:0]  done_q, done_d;
   logic [1:0]  gnt_c;
   logic        rd_c, wr_c, win;
   logic [31:0] merged;

   // Byte offset bits and any address bits above bit 7 carry no information here.
   logic unused_addr;
   assign unused_addr = ^{addr0, addr1};

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= IDLE;
         last_q   <= 1'b1;
         port_q   <= 1'b0;
         we_q     <= 1'b0;
         be_q     <= 4'h0;
         wdata_q  <= '0;
         maddr_q  <= '0;
         merge_q  <= '0;
         rdata0_q <= '0;
         rdata1_q <= '0;
         done_q   <= '0;
      end else begin
         state_q  <= state_d;
         last_q   <= last_d;
         port_q   <= port_d;
         we_q     <= we_d;
         be_q     <= be_d;
         wdata_q  <= wdata_d;
         maddr_q  <= maddr_d;
         merge_q  <= merge_d;
         rdata0_q <= rdata0_d;
         rdata1_q <= rdata1_d;
         done_q   <= done_d;
      end
   end

   always_comb begin
      merged = '0;
      for (int i = 0; i < 4; i++) begin
         merged[8*i +: 8] = be_q[i] ? wdata_q[8*i +: 8] : merge_q[8*i +: 8];
      end
   end

   always_comb begin
      state_d  = state_q;
      last_d   = last_q;
      port_d   = port_q;
      we_d     = we_q;
      be_d     = be_q;
      wdata_d  = wdata_q;
      maddr_d  = maddr_q;
      merge_d  = merge_q;
      rdata0_d = rdata0_q;
      rdata1_d = rdata1_q;
      done_d   = '0;
      gnt_c    = '0;
      rd_c     = 1'b0;
      wr_c     = 1'b0;
      win      = 1'b0;
      case (state_q)
         IDLE: begin
            if (|req) begin
               // On a tie the port that did not win last time gets the grant.
               win        = (req == 2'b11) ? ~last_q : req[1];
               gnt_c[win] = 1'b1;
               last_d     = win;
               port_d     = win;
               we_d       = win ? we[1]  : we[0];
               be_d       = win ? be1    : be0;
               wdata_d    = win ? wdata1 : wdata0;
               maddr_d    = {2'b00, (win ? addr1[7:2] : addr0[7:2])};
               state_d    = ACCESS;
            end
         end
         ACCESS: begin
            if (!we_q) begin
               rd_c = 1'b1;
               if (port_q) rdata1_d = mem_read_data;
               else        rdata0_d = mem_read_data;
               done_d[port_q] = 1'b1;
               state_d        = IDLE;
            end else if (be_q == 4'hF) begin
               wr_c           = 1'b1;
               done_d[port_q] = 1'b1;
               state_d        = IDLE;
            end else if (be_q == 4'h0) begin
               done_d[port_q] = 1'b1;
               state_d        = IDLE;
            end else begin
               rd_c    = 1'b1;
               merge_d = mem_read_data;
               state_d = MERGE;
            end
         end
         MERGE: begin
            wr_c           = 1'b1;
            done_d[port_q] = 1'b1;
            state_d        = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Combinational outputs are forced low while reset is asserted so an
   // aborted partial write never reaches memory in the reset cycle.
   assign gnt            = reset ? gnt_c : 2'b00;
   assign mem_read       = reset & rd_c;
   assign mem_write      = reset & wr_c;
   assign busy           = reset & (state_q != IDLE);
   assign done           = done_q;
   assign rdata0         = rdata0_q;
   assign rdata1         = rdata1_q;
   assign mem_addr       = maddr_q;
   assign mem_write_data = (state_q == MERGE) ? merged : wdata_q;

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have one parameter: ADDR_W, default 8, byte-address width of each requester port.
REQ-002 SHALL have one clock and a synchronous, active-low reset; the clock is named clk and the reset is named reset.
REQ-003 SHALL have the following ports:
  clk  in  1  clock; all state updates on its rising edge
  reset  in  1  synchronous, active-low reset
  req  in  2  per-port request; bit p belongs to port p (0 = CPU, 1 = debug/DMA)
  we  in  2  per-port write (1) / read (0)
  addr0, addr1  in  ADDR_W  per-port byte address; addr[1:0] ignored
  wdata0, wdata1  in  32  per-port write data
  be0, be1  in  4  per-port byte enables; be[i] selects bits 8i+7:8i
  gnt  out  2  one-cycle grant pulse per port
  done  out  2  one-cycle completion pulse per port
  rdata0, rdata1  out  32  per-port read data
  busy  out  1  high when the state is not IDLE
  mem_addr  out  8  D-MEM word index
  mem_write_data  out  32  D-MEM write data
  mem_read_data  in  32  D-MEM asynchronous read data
  mem_read, mem_write  out  1  D-MEM strobes

Function
REQ-004 SHALL implement the states IDLE, ACCESS and MERGE.
REQ-005 In IDLE with any req bit high, SHALL grant exactly one port, pulse gnt[p], latch that port's we/addr/wdata/be, and move to ACCESS.
REQ-006 Arbitration SHALL be round-robin: a single requester wins outright; if both request, the port not granted last wins; last_grant SHALL update on every grant.
REQ-007 Inputs SHALL be sampled only in the grant cycle; a requester may change or drop req from the next cycle; req still high after gnt SHALL count as a new request.
REQ-008 mem_addr SHALL equal {2'b00, latched addr[7:2]} in ACCESS and MERGE, and otherwise hold its last value.
REQ-009 Read, ACCESS: mem_read=1; capture mem_read_data into rdata[p]; go to IDLE.
REQ-010 Write with be=4'hF, ACCESS: mem_write=1; mem_write_data=latched wdata; go to IDLE.
REQ-011 Write with be=4'h0, ACCESS: no strobe asserted; go to IDLE; the transaction completes as a no-op.
REQ-012 Partial write (any other be), ACCESS: mem_read=1; latch mem_read_data into a merge register; go to MERGE.
REQ-013 Partial write, MERGE: mem_write=1; each byte lane takes wdata where be[i]=1 and the merge register otherwise; go to IDLE.
REQ-014 done[p] SHALL be a registered one-cycle pulse in the cycle after the final ACCESS or MERGE cycle.
REQ-015 rdata[p] SHALL be valid with done[p] and held until the next read completion on that port; writes SHALL leave rdata unchanged.
REQ-016 Latency from the gnt cycle T: done at T+2 for reads, full writes and be=0 writes; done at T+3 for partial writes.
REQ-017 SHALL be able to grant in the same IDLE cycle in which done pulses, giving one transaction per 2 cycles (3 for partial writes).
REQ-018 mem_read and mem_write SHALL never both be high, and SHALL both be 0 in IDLE.
REQ-019 busy SHALL be 1 in ACCESS and MERGE.

Reset
REQ-020 With reset low at a clock edge, SHALL enter IDLE, set last_grant=1 (port 0 wins the first tie), and clear gnt, done, rdata0, rdata1, mem_addr, mem_write_data, mem_read, mem_write, busy and the merge register.
REQ-021 Reset during ACCESS or MERGE SHALL abort the transaction: no mem_write in the reset cycle, no done pulse, and the memory word stays unchanged by the partial write.
REQ-022 The block SHALL NOT drive the D-MEM's own reset.

Verification
REQ-023 Port0 write addr=0x10, wdata=0xDEADBEEF, be=F, then port0 read of 0x10 -> mem_addr=0x04, mem_write for one cycle, rdata0=0xDEADBEEF with done[0] at T+2.
REQ-024 Word 0x10 holds 0xDEADBEEF; port1 write be=4'b0010, wdata=0x0000AA00 -> mem_read at T+1, mem_write at T+2 with 0xDEADAAEF, done[1] at T+3.
REQ-025 Both req held high from reset release -> grants alternate 0,1,0,1 and each done matches its grant.
REQ-026 Reset driven low during MERGE of the REQ-024 transaction -> no mem_write, no done, word reads back 0xDEADBEEF, busy=0.
REQ-027 Port0 write with be=0 -> no mem_read or mem_write, done[0] at T+2, memory unchanged.
REQ-028 Port1 read completes with rdata1=X, then a port0 write -> rdata1 still equals X.
